red_reduce_seq: RTL and testbench
=================================

// Module: red_reduce_seq
// PURPOSE
//   Multi-cycle, parametrised successor of the single-cycle RED byte-sum unit.
//   - Accepts a programmable number of DATA_W-bit operands over a valid/ready stream.
//   - Splits each operand into signed LANE_W-bit lanes and sums every lane of every operand.
//   - Returns a DATA_W result. Sits beside the ALU as a multi-cycle execute unit.
// PARAMETERS
//   DATA_W   16  operand/result width; must be a multiple of LANE_W
//   LANE_W    8  lane width; each lane is a two's-complement value
//   MAX_OPS   4  maximum operands per reduction (>=1)
// PORTS
//   clk       in   1                      rising-edge clock
//   rst_n     in   1                      async active-low reset
//   start     in   1                      begin a reduction; sampled only in IDLE
//   num_ops   in   $clog2(MAX_OPS+1)      operand count for this reduction; sampled with start
//   in_valid  in   1                      operand beat valid
//   in_ready  out  1                      unit can accept an operand
//   in_data   in   DATA_W                 operand
//   out_valid out  1                      result valid
//   out_ready in   1                      consumer accepts result
//   out_data  out  DATA_W                 reduction result
//   ovf       out  1                      full sum not representable in signed DATA_W; valid with out_valid
//   busy      out  1                      state != IDLE
// BEHAVIOUR
//   - LANES = DATA_W/LANE_W. ACC_W = DATA_W + $clog2(MAX_OPS*LANES) + 1. Accumulator is signed ACC_W.
//   - Reset (async, rst_n=0): state=IDLE, acc=0, remaining count=0.
//     All outputs 0: in_ready, out_valid, out_data, ovf, busy.
//   - FSM IDLE -> ACCUM -> DONE -> IDLE:
//     IDLE:  on start, clear acc and latch num_ops.
//            num_ops==0 -> DONE with result 0, ovf=0. num_ops>MAX_OPS is clamped to MAX_OPS.
//            Otherwise -> ACCUM.
//     ACCUM: in_ready=1. On each in_valid&&in_ready beat, acc += sum of sign-extended lanes
//            (computed in the same cycle) and the remaining count decrements.
//            The beat that brings the count to 0 moves to DONE.
//            in_valid low stalls indefinitely with no timeout.
//     DONE:  out_valid=1. out_data and ovf are registered and held stable until out_ready.
//            On out_valid&&out_ready -> IDLE.
//   - Latency: out_valid asserts the cycle after the final operand handshake.
//     Throughput is one operand per cycle.
//   - start is ignored outside IDLE. start in the same cycle the DONE handshake completes
//     is ignored; the unit must see IDLE first.
//   - in_ready=0 in IDLE/DONE, so beats offered there are not consumed.
//   - ovf=1 iff acc < -2^(DATA_W-1) or acc > 2^(DATA_W-1)-1.
//   - Default result = acc[DATA_W-1:0] (wrap). In-range sums are sign-extended, e.g. -1 -> 16'hFFFF.
//   - Compatibility: DATA_W=16, LANE_W=8, num_ops=2 with beats rs then rt
//     equals legacy RED(rs,rt) = a+b+c+d.
// CONFIGURATION
//   RED_SAT_EN defined:   on ovf, out_data saturates to 2^(DATA_W-1)-1 (positive overflow)
//                         or -2^(DATA_W-1) (negative overflow); ovf still reported.
//   RED_SAT_EN undefined: out_data wraps (low DATA_W bits); ovf still reported.
// STRUCTURE
//   - Package red_pkg: state enum {IDLE,ACCUM,DONE}; localparam helpers for LANES and ACC_W;
//     saturate function used under RED_SAT_EN.
//   - Sub-module red_lane_sum (combinational): DATA_W word -> signed sum of LANES
//     sign-extended lanes, width LANE_W+$clog2(LANES)+1.
//   - Top level holds the FSM, counter, accumulator and output register.
// TESTING
//   1. Defaults, num_ops=2, beats 16'h0101,16'h0101 -> out_data=16'h0004, ovf=0,
//      out_valid 1 cycle after 2nd beat.
//   2. Defaults, num_ops=4, beats 16'hFFFF x4 (8 lanes of -1) -> out_data=16'hFFF8, ovf=0.
//   3. num_ops=0 with start -> out_valid next cycle, out_data=0; no in_ready pulse.
//   4. Backpressure: out_ready=0 for 5 cycles -> out_data stable, in_ready=0, start ignored;
//      out_ready=1 -> IDLE next cycle.
//   5. DATA_W=16, LANE_W=16, num_ops=4, beats 16'h7FFF x4 -> ovf=1;
//      out_data=16'hFFFC without RED_SAT_EN, 16'h7FFF with it.
//   6. rst_n pulsed low mid-ACCUM after 1 of 3 beats -> all outputs 0 immediately.
//      Next reduction 16'h0102,16'h0304 (num_ops=2) -> 16'h000A.

Source files
------------

// File: rtl/red_pkg.sv
// Shared types and elaboration helpers for the lane-sum reduction unit.
// Latency: none (package only).
// Backpressure: not applicable.
package red_pkg;

    // Reduction control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } red_state_t;

    // Number of lanes in one operand word.
    function automatic int red_lanes(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

    // Accumulator width: holds MAX_OPS*LANES lanes of full-scale magnitude
    // plus one spare bit so overflow of the DATA_W result is detectable.
    function automatic int red_acc_w(input int data_w, input int lane_w, input int max_ops);
        return data_w + $clog2(max_ops * (data_w / lane_w)) + 1;
    endfunction

    // Width of the signed sum of all lanes of one word.
    function automatic int red_sum_w(input int data_w, input int lane_w);
        return lane_w + $clog2(data_w / lane_w) + 1;
    endfunction

    // Saturation value for a data_w-bit signed result: most negative value
    // when neg is set, most positive otherwise. Caller truncates to its width.
    function automatic logic [63:0] red_saturate(input logic neg, input int data_w);
        logic [63:0] max_pos;
        max_pos = (64'd1 << (data_w - 1)) - 64'd1;
        return neg ? ~max_pos : max_pos;
    endfunction

endpackage

// File: rtl/red_lane_sum.sv
// Combinational sum of all sign-extended LANE_W lanes of one DATA_W word.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
module red_lane_sum
    import red_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANE_W = 8,
    parameter int LANES  = red_lanes(DATA_W, LANE_W),
    parameter int SUM_W  = red_sum_w(DATA_W, LANE_W)
) (
    input  logic [DATA_W-1:0]       i_data,
    output logic signed [SUM_W-1:0] o_sum
);

    logic signed [SUM_W-1:0] w_sum;

    // Add every lane as a two's-complement value, widened before the add.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + SUM_W'($signed(i_data[i*LANE_W +: LANE_W]));
        end
    end

    assign o_sum = w_sum;

endmodule

// File: rtl/red_reduce_seq.sv
// Multi-cycle signed lane-sum reduction over a programmable number of operands.
// Latency: result valid the cycle after the final operand handshake; 1 operand/cycle.
// Backpressure: result held stable in DONE until out_ready; in_ready low outside ACCUM.
// Optional feature: RED_SAT_EN saturates out_data on overflow instead of wrapping.
module red_reduce_seq
    import red_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int LANE_W  = 8,
    parameter int MAX_OPS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [$clog2(MAX_OPS+1)-1:0]  num_ops,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic                          ovf,
    output logic                          busy
);

    localparam int CNT_W = $clog2(MAX_OPS + 1);
    localparam int LANES = red_lanes(DATA_W, LANE_W);
    localparam int ACC_W = red_acc_w(DATA_W, LANE_W, MAX_OPS);
    localparam int SUM_W = red_sum_w(DATA_W, LANE_W);
    localparam int HI_W  = ACC_W - DATA_W + 1;

    red_state_t                r_state;
    logic signed [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]          r_remaining;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic [DATA_W-1:0]         r_out_data;
    logic                      r_ovf;
    logic                      r_busy;

    logic signed [SUM_W-1:0]   w_lane_sum;
    logic signed [ACC_W-1:0]   w_acc_nxt;
    logic [HI_W-1:0]           w_hi;
    logic                      w_ovf;
    logic [DATA_W-1:0]         w_result;
    logic [CNT_W-1:0]          w_ops_clamped;

    red_lane_sum #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W),
        .LANES  (LANES),
        .SUM_W  (SUM_W)
    ) u_lane_sum (
        .i_data (in_data),
        .o_sum  (w_lane_sum)
    );

    // Next accumulator value and its DATA_W result / overflow, used on the final beat.
    // The sum fits signed DATA_W exactly when all bits from DATA_W-1 upward agree.
    always_comb begin
        w_acc_nxt = r_acc + ACC_W'(w_lane_sum);
        w_hi      = w_acc_nxt[ACC_W-1:DATA_W-1];
        w_ovf     = !((&w_hi) || (~|w_hi));
`ifdef RED_SAT_EN
        w_result  = w_ovf ? DATA_W'(red_saturate(w_acc_nxt[ACC_W-1], DATA_W))
                          : w_acc_nxt[DATA_W-1:0];
`else
        w_result  = w_acc_nxt[DATA_W-1:0];
`endif
        w_ops_clamped = (num_ops > CNT_W'(MAX_OPS)) ? CNT_W'(MAX_OPS) : num_ops;
    end

    // Control FSM with registered handshake outputs, counter, accumulator and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_remaining <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc  <= '0;
                        r_busy <= 1'b1;
                        if (num_ops == '0) begin
                            // Empty reduction: result 0, straight to DONE.
                            r_state     <= DONE;
                            r_remaining <= '0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= '0;
                            r_ovf       <= 1'b0;
                        end else begin
                            r_state     <= ACCUM;
                            r_remaining <= w_ops_clamped;
                            r_in_ready  <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid && r_in_ready) begin
                        r_acc       <= w_acc_nxt;
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_result;
                            r_ovf       <= w_ovf;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here; IDLE must be seen first.
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign ovf       = r_ovf;
    assign busy      = r_busy;

endmodule

// File: tb/tb_red_reduce_seq.sv
// Directed bench: two instances (8-bit lanes and one 16-bit lane) driven in lockstep.
// Latency: checks result appears exactly one cycle after the last beat.
// Backpressure: exercises held results, ignored start and blocked beats in DONE.
module tb_red_reduce_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  num_ops;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_ovf, a_busy;
    logic [15:0] a_out_data;
    logic        b_in_ready, b_out_valid, b_ovf, b_busy;
    logic [15:0] b_out_data;

    int n_checks = 0;
    int n_errors = 0;

    red_reduce_seq #(.DATA_W(16), .LANE_W(8), .MAX_OPS(4)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_ops   (num_ops),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_data   (in_data),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_data  (a_out_data),
        .ovf       (a_ovf),
        .busy      (a_busy)
    );

    red_reduce_seq #(.DATA_W(16), .LANE_W(16), .MAX_OPS(4)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_ops   (num_ops),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_data   (in_data),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_data  (b_out_data),
        .ovf       (b_ovf),
        .busy      (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a reduction and feed nb beats back to back; ends 1 cycle after last beat.
    task automatic reduce(input string tag, input logic [2:0] n, input int nb,
                          input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3);
        logic [15:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        start   = 1'b1;
        num_ops = n;
        step();
        start   = 1'b0;
        for (int i = 0; i < nb; i++) begin
            chk({tag, "_rdy"}, {31'd0, a_in_ready}, 32'd1);
            chk({tag, "_vld_early"}, {31'd0, a_out_valid}, 32'd0);
            in_valid = 1'b1;
            in_data  = d[i];
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;
        chk({tag, "_vld"}, {31'd0, a_out_valid}, 32'd1);
        chk({tag, "_rdy_done"}, {31'd0, a_in_ready}, 32'd0);
    endtask

    // Complete the result handshake and confirm both units return to IDLE.
    task automatic drain(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_idle_vld"}, {31'd0, a_out_valid}, 32'd0);
        chk({tag, "_idle_busy"}, {30'd0, a_busy, b_busy}, 32'd0);
    endtask

    logic [15:0] held;

    initial begin
        rst_n = 1'b0; start = 1'b0; num_ops = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        chk("rst_outs_a", {27'd0, a_in_ready, a_out_valid, a_ovf, a_busy, 1'b0}, 32'd0);
        chk("rst_data_a", {16'd0, a_out_data}, 32'd0);
        chk("rst_outs_b", {28'd0, b_in_ready, b_out_valid, b_ovf, b_busy}, 32'd0);
        #2 rst_n = 1'b1;
        step();

        // Basic two-beat reduction: 4 lanes of +1.
        reduce("t1", 3'd2, 2, 16'h0101, 16'h0101, 16'h0, 16'h0);
        chk("t1_data_a", {16'd0, a_out_data}, 32'h0004);
        chk("t1_ovf_a", {31'd0, a_ovf}, 32'd0);
        chk("t1_data_b", {16'd0, b_out_data}, 32'h0202);
        drain("t1");

        // Eight lanes of -1 gives a sign-extended negative result.
        reduce("t2", 3'd4, 4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        chk("t2_data_a", {16'd0, a_out_data}, 32'hFFF8);
        chk("t2_ovf_a", {31'd0, a_ovf}, 32'd0);
        chk("t2_data_b", {16'd0, b_out_data}, 32'hFFFC);
        drain("t2");

        // Empty reduction: immediate result 0 with no in_ready pulse.
        start = 1'b1; num_ops = 3'd0;
        step();
        start = 1'b0;
        chk("t3_vld", {31'd0, a_out_valid}, 32'd1);
        chk("t3_rdy", {30'd0, a_in_ready, b_in_ready}, 32'd0);
        chk("t3_data", {16'd0, a_out_data}, 32'h0000);
        drain("t3");

        // Backpressure: result held, beats blocked, start ignored while in DONE.
        reduce("t4", 3'd1, 1, 16'h8080, 16'h0, 16'h0, 16'h0);
        held = a_out_data;
        chk("t4_data_a", {16'd0, a_out_data}, 32'hFF00);
        chk("t4_data_b", {16'd0, b_out_data}, 32'h8080);
        chk("t4_ovf_b", {31'd0, b_ovf}, 32'd0);
        start = 1'b1; num_ops = 3'd2; in_valid = 1'b1; in_data = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold", {16'd0, a_out_data}, {16'd0, held});
            chk("t4_hold_vld", {31'd0, a_out_valid}, 32'd1);
            chk("t4_hold_rdy", {31'd0, a_in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        // start still high during the completing handshake: must be ignored.
        drain("t4");
        start = 1'b0;
        step();
        chk("t4_no_restart", {30'd0, a_busy, b_busy}, 32'd0);

        // Positive overflow on the single 16-bit-lane unit.
        reduce("t5", 3'd4, 4, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        chk("t5_ovf_b", {31'd0, b_ovf}, 32'd1);
`ifdef RED_SAT_EN
        chk("t5_data_b", {16'd0, b_out_data}, 32'h7FFF);
`else
        chk("t5_data_b", {16'd0, b_out_data}, 32'hFFFC);
`endif
        chk("t5_data_a", {16'd0, a_out_data}, 32'h01F8);
        chk("t5_ovf_a", {31'd0, a_ovf}, 32'd0);
        drain("t5");

        // Negative overflow on the 16-bit-lane unit.
        reduce("t5n", 3'd4, 4, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        chk("t5n_ovf_b", {31'd0, b_ovf}, 32'd1);
`ifdef RED_SAT_EN
        chk("t5n_data_b", {16'd0, b_out_data}, 32'h8000);
`else
        chk("t5n_data_b", {16'd0, b_out_data}, 32'h0000);
`endif
        chk("t5n_data_a", {16'd0, a_out_data}, 32'hFE00);
        drain("t5n");

        // num_ops above MAX_OPS is clamped: four beats complete the reduction.
        reduce("clamp", 3'd7, 4, 16'h0101, 16'h0101, 16'h0101, 16'h0101);
        chk("clamp_data_a", {16'd0, a_out_data}, 32'h0008);
        chk("clamp_data_b", {16'd0, b_out_data}, 32'h0404);
        drain("clamp");

        // Asynchronous reset mid-ACCUM clears everything at once.
        start = 1'b1; num_ops = 3'd3;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'h7777;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_a", {27'd0, a_in_ready, a_out_valid, a_ovf, a_busy, 1'b0}, 32'd0);
        chk("t6_rst_b", {28'd0, b_in_ready, b_out_valid, b_ovf, b_busy}, 32'd0);
        chk("t6_rst_data", {a_out_data, b_out_data}, 32'd0);
        #2 rst_n = 1'b1;
        step();
        reduce("t6", 3'd2, 2, 16'h0102, 16'h0304, 16'h0, 16'h0);
        chk("t6_data_a", {16'd0, a_out_data}, 32'h000A);
        chk("t6_data_b", {16'd0, b_out_data}, 32'h0406);
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
